// File: rtl/data_mem_responder.sv
// Multi-cycle RV32I data-memory responder behind valid/ready request and response channels.
// Optional build macro MISALIGN_ALLOW_EN lets misaligned accesses complete with one extra wait cycle.
module data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic isLegal(input logic wr, input logic [2:0] f3);
        if (wr)
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    logic [7:0]            mem [DEPTH];

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  extraCycle;
    logic                  accessLegal;
    logic                  accessMis;
    logic                  accessErr;
    logic                  fire;
    logic [2:0]            nBytes;
    logic [ADDR_WIDTH-1:0] byteAddr [4];
    logic [7:0]            rdByte [4];
    logic [31:0]           loadData;
    logic                  storeEn [4];
    logic                  unusedAddrBits;

    assign unusedAddrBits = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

    assign accessLegal = isLegal(write_q, funct3_q);
    assign accessMis   = accessLegal && isMisaligned(funct3_q, addr_q[1:0]);

`ifdef MISALIGN_ALLOW_EN
    assign extraCycle = isLegal(req_write, req_funct3) && isMisaligned(req_funct3, req_addr[1:0]);
    assign accessErr  = !accessLegal;
`else
    assign extraCycle = 1'b0;
    assign accessErr  = !accessLegal || accessMis;
`endif

    assign fire = (state_q == ST_WAIT) && (count_q == '0);

    always_comb begin
        nBytes = 3'd4;
        case (funct3_q[1:0])
            2'b00:   nBytes = 3'd1;
            2'b01:   nBytes = 3'd2;
            default: nBytes = 3'd4;
        endcase
    end

    // Byte lanes wrap modulo the storage size, which only matters for misaligned accesses.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byteAddr[k] = addr_q + ADDR_WIDTH'(k);
            rdByte[k]   = mem[byteAddr[k]];
            storeEn[k]  = fire && write_q && !accessErr && (k < int'(nBytes));
        end
    end

    always_comb begin
        loadData = '0;
        case (funct3_q)
            3'b000:  loadData = {{24{rdByte[0][7]}}, rdByte[0]};
            3'b001:  loadData = {{16{rdByte[1][7]}}, rdByte[1], rdByte[0]};
            3'b010:  loadData = {rdByte[3], rdByte[2], rdByte[1], rdByte[0]};
            3'b100:  loadData = {24'b0, rdByte[0]};
            3'b101:  loadData = {16'b0, rdByte[1], rdByte[0]};
            default: loadData = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (storeEn[k])
                mem[byteAddr[k]] <= wdata_q[8*k +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        write_d  = write_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    write_d  = req_write;
                    addr_d   = req_addr[ADDR_WIDTH-1:0];
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    count_d  = CW'(LATENCY - 1) + {{(CW-1){1'b0}}, extraCycle};
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (count_q == '0) begin
                    rdata_d = (write_q || accessErr) ? '0 : DATA_WIDTH'(loadData);
                    err_d   = accessErr;
                    state_d = ST_RESP;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = rst && (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder, checked against a byte-array reference model.
// Honours MISALIGN_ALLOW_EN the same way as the design.
module tb_data_mem_responder;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [0:4095];

    always #5 clk = ~clk;

    data_mem_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(12),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_funct3(req_funct3),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: RV32I access rules applied to a flat little-endian byte array.
    task automatic modelAccess(input bit wr, input logic [31:0] addr, input logic [2:0] f3,
                               input logic [31:0] wd, output logic [31:0] rd,
                               output logic err, output int lat);
        int     n;
        int     base;
        bit     legal;
        bit     signedLd;
        bit     mis;
        longint val;
        legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        case (f3)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            default:    n = 4;
        endcase
        signedLd = (f3 == 3'd0) || (f3 == 3'd1);
        base = int'(addr % 32'd4096);
        mis  = legal && ((base % n) != 0);
        lat  = LATENCY;
        err  = !legal;
`ifdef MISALIGN_ALLOW_EN
        if (mis) lat = LATENCY + 1;
`else
        if (mis) err = 1'b1;
`endif
        rd = '0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < n; i++)
                    mdl[(base + i) % 4096] = wd[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < n; i++)
                    val += longint'(mdl[(base + i) % 4096]) << (8 * i);
                if (signedLd && val >= (longint'(1) << (8 * n - 1)))
                    val -= (longint'(1) << (8 * n));
                rd = val[31:0];
            end
        end
    endtask

    // Issues one request and measures cycles from the accept edge to rsp_valid.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [2:0] f3,
                                 input logic [31:0] wd, output logic [31:0] rd,
                                 output logic err, output int lat);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("req_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd  = rsp_rdata;
        err = rsp_err;
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runAndCheck(input string tag, input bit wr, input logic [31:0] addr,
                               input logic [2:0] f3, input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] expRd;
        logic        expErr, gotErr;
        int          expLat, gotLat;
        modelAccess(wr, addr, f3, wd, expRd, expErr, expLat);
        applyStimulus(wr, addr, f3, wd, rd, gotErr, gotLat);
        checkOutput({tag, "_rdata"}, rd, expRd);
        checkOutput({tag, "_err"}, 32'(gotErr), 32'(expErr));
        checkOutput({tag, "_lat"}, 32'(gotLat), 32'(expLat));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] held;
        logic [31:0] v;
        logic [31:0] addr;
        logic        e;
        int          lat;

        #1 rst = 1'b0;
        #11;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk) rst = 1'b1;
        #1 checkOutput("post_reset_req_ready", 32'(req_ready), 32'd1);

        for (int a = 32'h100; a < 32'h210; a += 4)
            runAndCheck("init_sw", 1'b1, 32'(a), 3'b010, $urandom, rd);

        runAndCheck("t1_sw", 1'b1, 32'h100, 3'b010, 32'hDEADBEEF, rd);
        checkOutput("t1_sw_zero", rd, 32'h0);
        runAndCheck("t1_lw_alias", 1'b0, 32'h1100, 3'b010, 32'h0, rd);
        checkOutput("t1_lw_const", rd, 32'hDEADBEEF);
        runAndCheck("lb", 1'b0, 32'h100, 3'b000, 32'h0, rd);
        checkOutput("lb_const", rd, 32'hFFFFFFEF);
        runAndCheck("lbu", 1'b0, 32'h103, 3'b100, 32'h0, rd);
        checkOutput("lbu_const", rd, 32'h000000DE);
        runAndCheck("lh", 1'b0, 32'h102, 3'b001, 32'h0, rd);
        checkOutput("lh_const", rd, 32'hFFFFDEAD);
        runAndCheck("lhu", 1'b0, 32'h100, 3'b101, 32'h0, rd);
        checkOutput("lhu_const", rd, 32'h0000BEEF);
        runAndCheck("sb", 1'b1, 32'h101, 3'b000, 32'hFFFFFF12, rd);
        runAndCheck("lw_after_sb", 1'b0, 32'h100, 3'b010, 32'h0, rd);
        checkOutput("lw_after_sb_const", rd, 32'hDEAD12EF);
        runAndCheck("sh", 1'b1, 32'h102, 3'b001, 32'h00005A5A, rd);
        runAndCheck("lw_after_sh", 1'b0, 32'h100, 3'b010, 32'h0, rd);
        checkOutput("lw_after_sh_const", rd, 32'h5A5A12EF);

        // Backpressure: response held while a stray request pulse must be ignored.
        rsp_ready = 1'b0;
        modelAccess(1'b0, 32'h104, 3'b010, 32'h0, v, e, lat);
        applyStimulus(1'b0, 32'h104, 3'b010, 32'h0, held, e, lat);
        checkOutput("bp_rdata", held, v);
        checkOutput("bp_lat", 32'(lat), 32'(LATENCY));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) begin
                req_valid  = 1'b1;
                req_write  = 1'b1;
                req_addr   = 32'h104;
                req_funct3 = 3'b010;
                req_wdata  = 32'h11111111;
            end else begin
                req_valid = 1'b0;
            end
            #1;
            checkOutput("bp_valid_hold", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rdata_hold", rsp_rdata, held);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 checkOutput("bp_release", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 checkOutput("bp_no_extra_rsp", 32'(rsp_valid), 32'd0);
        end
        runAndCheck("bp_word_intact", 1'b0, 32'h104, 3'b010, 32'h0, rd);

`ifdef MISALIGN_ALLOW_EN
        runAndCheck("mis_lw", 1'b0, 32'h101, 3'b010, 32'h0, rd);
        modelAccess(1'b0, 32'h101, 3'b010, 32'h0, v, e, lat);
        checkOutput("mis_lw_model_lat", 32'(lat), 32'(LATENCY + 1));
        runAndCheck("mis_sh", 1'b1, 32'h105, 3'b001, 32'h0000C3A5, rd);
        runAndCheck("mis_lhu", 1'b0, 32'h105, 3'b101, 32'h0, rd);
        checkOutput("mis_lhu_const", rd, 32'h0000C3A5);
`else
        runAndCheck("mis_lw", 1'b0, 32'h102, 3'b010, 32'h0, rd);
        checkOutput("mis_lw_rdata_const", rd, 32'h0);
        runAndCheck("mis_sh", 1'b1, 32'h101, 3'b001, 32'h0000FFFF, rd);
        runAndCheck("lw_after_mis_sh", 1'b0, 32'h100, 3'b010, 32'h0, rd);
        checkOutput("lw_after_mis_sh_const", rd, 32'h5A5A12EF);
`endif
        modelAccess(1'b0, 32'h100, 3'b011, 32'h0, v, e, lat);
        applyStimulus(1'b0, 32'h100, 3'b011, 32'h0, rd, e, lat);
        checkOutput("illegal_f3_err", 32'(e), 32'd1);
        checkOutput("illegal_f3_rdata", rd, 32'h0);

        for (int i = 0; i < 60; i++) begin
            addr = ($urandom & 32'hFFFFF000) | (32'h100 + 32'($urandom_range(0, 255)));
            runAndCheck($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), addr,
                        3'($urandom_range(0, 7)), $urandom, rd);
        end

        // Reset while a store waits: it must vanish without committing.
        runAndCheck("rst_pre_lw", 1'b0, 32'h200, 3'b010, 32'h0, v);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h200;
        req_funct3 = 3'b010;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_wait_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_wait_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_wait_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_wait_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        runAndCheck("rst_post_lw", 1'b0, 32'h200, 3'b010, 32'h0, rd);
        checkOutput("rst_post_lw_same", rd, v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
